// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared state type, default width and frame-length helper for the deserializer
package shift_deser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction
endpackage

// File: rtl/shift_deser_bitcnt.sv
// shift_deser_bitcnt: frame bit counter with clear, increment and last-bit flag
module shift_deser_bitcnt #(
  parameter int FRAME = 8,
  localparam int CW = $clog2(FRAME + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (clr) count <= inc ? CW'(1) : '0;
    else if (inc) count <= last ? '0 : count + 1'b1;
  assign last = count == CW'(FRAME - 1);
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first serial-in/parallel-out receiver with valid/ready output and sticky overrun
// Define SHIFT_DESER_PARITY_EN to append an even-parity bit to every frame and report parity_err.
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err
);
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = frame_len(WIDTH, PAR_EN);
  state_t state;
  logic [WIDTH-1:0] sr, word;
  logic last, done, load;
  shift_deser_bitcnt #(.FRAME(FRAME)) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (sync),
    .inc  (bit_valid),
    .last (last)
  );
  // with parity the final bit is not data, so the word is already fully shifted in
  always_comb begin
    done = bit_valid & ~sync & last;
    word = PAR_EN ? sr : {data_in, sr[WIDTH-1:1]};
    load = done & (~data_valid | data_ready);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
    end else if (sync) begin
      state <= bit_valid ? SHIFT : IDLE;
      sr    <= bit_valid ? {data_in, {(WIDTH-1){1'b0}}} : '0;
    end else if (bit_valid) begin
      state <= done ? IDLE : SHIFT;
      if (!(PAR_EN && last)) sr <= {data_in, sr[WIDTH-1:1]};
    end
  always_ff @(posedge clk)
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
      overrun <= (done & data_valid & ~data_ready) | (overrun & ~overrun_clr);
    end
  assign busy = state == SHIFT;
`ifdef SHIFT_DESER_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk)
    if (rst) perr_q <= 1'b0;
    else if (load) perr_q <= ^sr ^ data_in;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule
